// File: rtl/mc_port_alloc_if.sv
// Handshake bundle between multicast route computation and the output-port allocator.
// The master side drives the flit requests, the slave side returns the registered allocation.
interface mc_port_alloc_if #(
  parameter int NUM_IN   = 4,
  parameter int NUM_PORT = 5,
  parameter int AGE_W    = 8,
  parameter int ID_W     = 4,
  parameter int CNT_W    = 16
);
  logic [NUM_IN-1:0]          in_valid;
  logic [NUM_IN*AGE_W-1:0]    in_age;
  logic [NUM_IN*ID_W-1:0]     in_src;
  logic [NUM_IN*NUM_PORT-1:0] in_ppv;
  logic [NUM_PORT-1:0]        out_valid;
  logic [NUM_PORT*2-1:0]      out_sel;
  logic [NUM_IN-1:0]          out_deflect;
  logic [NUM_IN-1:0]          out_fork;
  logic [ID_W-1:0]            golden_id;
  logic [CNT_W-1:0]           deflect_cnt;

  modport master (
    output in_valid, in_age, in_src, in_ppv,
    input  out_valid, out_sel, out_deflect, out_fork, golden_id, deflect_cnt
  );

  modport slave (
    input  in_valid, in_age, in_src, in_ppv,
    output out_valid, out_sel, out_deflect, out_fork, golden_id, deflect_cnt
  );
endinterface

// File: rtl/mc_port_alloc.sv
// Registered output-port allocator for the bufferless multicast router: ranks flits,
// grants productive ports (forking multicast when capacity allows) and deflects the rest.
module mc_port_alloc #(
  parameter int NUM_IN       = 4,
  parameter int NUM_PORT     = 5,
  parameter int AGE_W        = 8,
  parameter int ID_W         = 4,
  parameter int NUM_NODES    = 16,
  parameter int GOLDEN_EPOCH = 256,
  parameter int CNT_W        = 16
) (
  input logic            clk,
  input logic            reset,
  mc_port_alloc_if.slave alloc
);
  localparam int EPOCH_W = $clog2(GOLDEN_EPOCH);
  localparam int SEL_W   = 2;
  localparam int NUM_NET = 4;

  logic [NUM_PORT-1:0]       outValid_q, outValid_d;
  logic [NUM_PORT*SEL_W-1:0] outSel_q, outSel_d;
  logic [NUM_IN-1:0]         outDeflect_q, outDeflect_d;
  logic [NUM_IN-1:0]         outFork_q, outFork_d;
  logic [ID_W-1:0]           goldenId_q, goldenId_d;
  logic [EPOCH_W-1:0]        epoch_q, epoch_d;
  logic [CNT_W-1:0]          deflectCnt_q, deflectCnt_d;
  logic [CNT_W:0]            deflSum;

  logic [NUM_IN-1:0]   isGolden;
  logic [AGE_W-1:0]    age [NUM_IN];
  logic [NUM_PORT-1:0] ppv [NUM_IN];
  int                  rank [NUM_IN];
  int                  numValid;

  logic [NUM_PORT-1:0] free, want, grant;
  int                  freeNet, cap, taken, granted;
  logic                placed;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      age[i]      = alloc.in_age[i*AGE_W +: AGE_W];
      ppv[i]      = alloc.in_ppv[i*NUM_PORT +: NUM_PORT];
      isGolden[i] = alloc.in_valid[i] && (alloc.in_src[i*ID_W +: ID_W] == goldenId_q);
    end
  end

  // rank[i] = number of valid flits that outrank flit i (golden, then older, then lower index)
  always_comb begin
    numValid = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      rank[i] = 0;
      if (alloc.in_valid[i]) numValid++;
      for (int j = 0; j < NUM_IN; j++) begin
        if (j != i && alloc.in_valid[j] &&
            ((isGolden[j] && !isGolden[i]) ||
             ((isGolden[j] == isGolden[i]) &&
              ((age[j] > age[i]) || ((age[j] == age[i]) && (j < i))))))
          rank[i]++;
      end
    end
  end

  // Network grants are capped so every lower-ranked flit still finds a free network port
  always_comb begin
    free         = '1;
    want         = '0;
    grant        = '0;
    freeNet      = 0;
    cap          = 0;
    taken        = 0;
    granted      = 0;
    placed       = 1'b0;
    outValid_d   = '0;
    outSel_d     = '0;
    outDeflect_d = '0;
    outFork_d    = '0;
    for (int r = 0; r < NUM_IN; r++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (alloc.in_valid[i] && rank[i] == r) begin
          freeNet = 0;
          for (int p = 0; p < NUM_NET; p++) if (free[p]) freeNet++;
          cap = freeNet - (numValid - 1 - r);
          if (cap < 1) cap = 1;
          want  = ppv[i] & free;
          grant = '0;
          grant[NUM_PORT-1] = want[NUM_PORT-1];
          taken = 0;
          for (int p = 0; p < NUM_NET; p++) begin
            if (want[p] && taken < cap) begin
              grant[p] = 1'b1;
              taken++;
            end
          end
          if (grant == '0) begin
            outDeflect_d[i] = 1'b1;
            placed = 1'b0;
            for (int p = 0; p < NUM_NET; p++) begin
              if (free[p] && !placed) begin
                grant[p] = 1'b1;
                placed   = 1'b1;
              end
            end
          end
          granted = 0;
          for (int p = 0; p < NUM_PORT; p++) if (grant[p]) granted++;
          outFork_d[i] = (granted >= 2);
          for (int p = 0; p < NUM_PORT; p++) begin
            if (grant[p]) begin
              outValid_d[p]                 = 1'b1;
              outSel_d[p*SEL_W +: SEL_W]    = SEL_W'(i);
            end
          end
          free = free & ~grant;
        end
      end
    end
  end

  always_comb begin
    epoch_d    = epoch_q + 1'b1;
    goldenId_d = goldenId_q;
    if (epoch_q == EPOCH_W'(GOLDEN_EPOCH - 1)) begin
      epoch_d    = '0;
      goldenId_d = (goldenId_q == ID_W'(NUM_NODES - 1)) ? '0 : goldenId_q + 1'b1;
    end
    deflSum = {1'b0, deflectCnt_q};
    for (int i = 0; i < NUM_IN; i++) deflSum = deflSum + (CNT_W+1)'(outDeflect_d[i]);
    deflectCnt_d = deflSum[CNT_W] ? '1 : deflSum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q   <= '0;
      outSel_q     <= '0;
      outDeflect_q <= '0;
      outFork_q    <= '0;
      goldenId_q   <= '0;
      epoch_q      <= '0;
      deflectCnt_q <= '0;
    end else begin
      outValid_q   <= outValid_d;
      outSel_q     <= outSel_d;
      outDeflect_q <= outDeflect_d;
      outFork_q    <= outFork_d;
      goldenId_q   <= goldenId_d;
      epoch_q      <= epoch_d;
      deflectCnt_q <= deflectCnt_d;
    end
  end

  assign alloc.out_valid   = outValid_q;
  assign alloc.out_sel     = outSel_q;
  assign alloc.out_deflect = outDeflect_q;
  assign alloc.out_fork    = outFork_q;
  assign alloc.golden_id   = goldenId_q;
  assign alloc.deflect_cnt = deflectCnt_q;
endmodule

// File: tb/tb_mc_port_alloc.sv
// Scoreboard bench for mc_port_alloc: a reference model predicts each cycle's allocation,
// a monitor compares it against the registered outputs one cycle later.
module tb_mc_port_alloc;
  localparam int GOLDEN_EPOCH = 256;
  localparam int NUM_NODES    = 16;
  localparam int CNT_MAX      = 65535;

  typedef struct packed {
    logic [4:0]  valid;
    logic [9:0]  sel;
    logic [3:0]  defl;
    logic [3:0]  forkV;
    logic [3:0]  golden;
    logic [15:0] dcnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_port_alloc_if bus ();
  mc_port_alloc dut (.clk(clk), .reset(reset), .alloc(bus));

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   mCycles = 0;
  int   mDcnt   = 0;

  // Reference: sort flits by a single numeric priority, then hand out ports in that order
  function automatic exp_t model(input logic rst, input logic [3:0] v, input logic [31:0] ages,
                                 input logic [15:0] srcs, input logic [19:0] ppvs);
    exp_t       e;
    int         key [4];
    bit         used [4];
    int         order[$];
    logic [4:0] free;
    logic [4:0] pv;
    int         g, n, best, avail, cap, net, cnt, total_d;
    e = '0;
    if (rst) return e;
    g = (mCycles / GOLDEN_EPOCH) % NUM_NODES;
    for (int i = 0; i < 4; i++) begin
      used[i] = 1'b0;
      key[i]  = ((srcs[i*4 +: 4] == 4'(g)) ? 100000 : 0) + int'(ages[i*8 +: 8]) * 4 + (3 - i);
    end
    for (int k = 0; k < 4; k++) begin
      best = -1;
      for (int i = 0; i < 4; i++)
        if (v[i] && !used[i] && (best < 0 || key[i] > key[best])) best = i;
      if (best >= 0) begin
        order.push_back(best);
        used[best] = 1'b1;
      end
    end
    n = order.size();
    free = 5'b11111;
    for (int r = 0; r < n; r++) begin
      int i;
      i = order[r];
      pv = ppvs[i*5 +: 5];
      avail = 0;
      for (int p = 0; p < 4; p++) if (free[p]) avail++;
      cap = avail - (n - 1 - r);
      if (cap < 1) cap = 1;
      cnt = 0;
      net = 0;
      if (pv[4] && free[4]) begin
        free[4] = 1'b0; e.valid[4] = 1'b1; e.sel[8 +: 2] = 2'(i); cnt++;
      end
      for (int p = 0; p < 4; p++) begin
        if (pv[p] && free[p] && net < cap) begin
          free[p] = 1'b0; e.valid[p] = 1'b1; e.sel[p*2 +: 2] = 2'(i); cnt++; net++;
        end
      end
      if (cnt == 0) begin
        e.defl[i] = 1'b1;
        for (int p = 0; p < 4; p++) begin
          if (free[p] && cnt == 0) begin
            free[p] = 1'b0; e.valid[p] = 1'b1; e.sel[p*2 +: 2] = 2'(i); cnt++;
          end
        end
      end
      e.forkV[i] = (cnt >= 2);
    end
    e.golden = 4'(((mCycles + 1) / GOLDEN_EPOCH) % NUM_NODES);
    total_d = mDcnt + $countones(e.defl);
    if (total_d > CNT_MAX) total_d = CNT_MAX;
    e.dcnt = 16'(total_d);
    return e;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [3:0] v, input logic [31:0] ages,
                               input logic [15:0] srcs, input logic [19:0] ppvs);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    bus.in_valid = v;
    bus.in_age   = ages;
    bus.in_src   = srcs;
    bus.in_ppv   = ppvs;
    e = model(rst, v, ages, srcs, ppvs);
    @(posedge clk);
    expQ.push_back(e);
    if (rst) begin
      mCycles = 0;
      mDcnt   = 0;
    end else begin
      mCycles++;
      mDcnt = int'(e.dcnt);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, mCycles, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'b0000, 32'h0, 16'h0, 20'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("out_valid",   32'(bus.out_valid),   32'(e.valid));
        checkOutput("out_sel",     32'(bus.out_sel),     32'(e.sel));
        checkOutput("out_deflect", 32'(bus.out_deflect), 32'(e.defl));
        checkOutput("out_fork",    32'(bus.out_fork),    32'(e.forkV));
        checkOutput("golden_id",   32'(bus.golden_id),   32'(e.golden));
        checkOutput("deflect_cnt", 32'(bus.deflect_cnt), 32'(e.dcnt));
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = '0;
    bus.in_age   = '0;
    bus.in_src   = '0;
    bus.in_ppv   = '0;
    applyStimulus(1'b1, 4'b0000, 32'h0, 16'h0, 20'h0);
    applyStimulus(1'b1, 4'b0000, 32'h0, 16'h0, 20'h0);
    idle(3);
    $display("[TB] directed cases");
    applyStimulus(1'b0, 4'b0001, 32'h0, 16'h1111, 20'h00002);
    applyStimulus(1'b0, 4'b1001, {8'd9, 8'd0, 8'd0, 8'd5}, 16'h1111,
                  {5'b00010, 5'b00000, 5'b00000, 5'b00010});
    applyStimulus(1'b0, 4'b0001, 32'h0, 16'h1111, {15'h0, 5'b10110});
    applyStimulus(1'b0, 4'b1111, {8'd20, 8'd30, 8'd40, 8'd50}, 16'h1111,
                  {5'b00001, 5'b00001, 5'b00001, 5'b01111});
    applyStimulus(1'b0, 4'b0011, {8'd0, 8'd0, 8'd7, 8'd7}, 16'h1111, 20'h0);
    applyStimulus(1'b0, 4'b0001, 32'h0, 16'h1111, {15'h0, 5'b10000});
    $display("[TB] random traffic");
    repeat (400)
      applyStimulus(1'b0, 4'($urandom), $urandom, 16'($urandom), 20'($urandom));
    while (mCycles < 3 * GOLDEN_EPOCH) idle(1);
    $display("[TB] golden override, then reset mid-traffic");
    applyStimulus(1'b0, 4'b0110, {8'd0, 8'd0, 8'd255, 8'd0}, 16'h0300,
                  {5'b00000, 5'b00010, 5'b00010, 5'b00000});
    applyStimulus(1'b1, 4'b1111, $urandom, 16'($urandom), 20'($urandom));
    idle(NUM_NODES * GOLDEN_EPOCH + 4);
    repeat (10) if (expQ.size() > 0) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
